bf16_pack_wb: RTL and testbench

- Writeback packer directly downstream of the FP32→BF16 conversion stage.
- Takes one registered BF16 result plus its 4-bit fpcsr per valid cycle and packs two results into one 32-bit word.
- Buffers packed words in a small FIFO and presents them to the register-file/memory writeback port over a valid/ready handshake.
- Keeps sticky exception flags for software readback.

---
 rtl/bf16_pkg.sv | 38 +++
 rtl/bf16_pack_wb_if.sv | 27 ++
 rtl/bf16_sync_fifo.sv | 56 +++++
 rtl/bf16_pack_wb.sv | 98 +++++++++
 tb/tb_bf16_pack_wb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared types and constants for the BF16 writeback packer.
// A packed word carries two BF16 halves plus lane enables and merged exception flags.
package bf16_pkg;

  typedef logic [15:0] bf16_t;
  typedef logic [3:0]  fpcsr_t;

  localparam int FPCSR_NV = 3;
  localparam int FPCSR_OF = 2;
  localparam int FPCSR_UF = 1;
  localparam int FPCSR_NX = 0;

  localparam bf16_t BF16_QNAN = 16'h7FC0;

  localparam logic [1:0] LANES_PAIR = 2'b11;
  localparam logic [1:0] LANES_LONE = 2'b01;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  lanes;
    fpcsr_t      flags;
  } pack_word_t;

  typedef enum logic {
    PACK_EMPTY = 1'b0,
    PACK_HALF  = 1'b1
  } pack_state_t;

  function automatic pack_word_t make_word(input bf16_t hi, input bf16_t lo,
                                           input logic [1:0] lanes, input fpcsr_t flags);
    pack_word_t w;
    w.data  = {hi, lo};
    w.lanes = lanes;
    w.flags = flags;
    return w;
  endfunction

endpackage

// File: rtl/bf16_pack_wb_if.sv
// Converter-side input and writeback-side output of the packer.
// Handshake: a word moves on a clock edge where out_valid && out_ready are both high;
// out_* stay stable while out_valid && !out_ready. in_valid is never stalled: in_ready is advisory only.
interface bf16_pack_wb_if;
  import bf16_pkg::*;

  logic        in_valid;
  bf16_t       in_result;
  fpcsr_t      in_fpcsr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lanes;
  fpcsr_t      out_flags;

  modport slave (
    input  in_valid, in_result, in_fpcsr, out_ready,
    output in_ready, out_valid, out_data, out_lanes, out_flags
  );

  modport master (
    output in_valid, in_result, in_fpcsr, out_ready,
    input  in_ready, out_valid, out_data, out_lanes, out_flags
  );

endinterface

// File: rtl/bf16_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full only lands if a pop frees the slot that cycle.
// rdata reads as zero while empty so the output port is clean after reset.
module bf16_sync_fifo
  import bf16_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pack_word_t,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bf16_pack_wb.sv
// Packs pairs of BF16 converter results into 32-bit writeback words, buffers them,
// and keeps sticky exception and overflow status for software.
module bf16_pack_wb
  import bf16_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  bf16_pack_wb_if.slave     bus,
  input  logic              flush,
  input  logic              flags_clear,
  output fpcsr_t            sticky_flags,
  output logic              drop_err,
  output logic [LVL_W-1:0]  level,
  output pack_state_t       pack_state
);

  bf16_t      pend_result;
  fpcsr_t     pend_flags;
  logic       push;
  pack_word_t push_word;
  pack_word_t head_word;
  logic       fifo_full;
  logic       fifo_empty;
  logic       head_pop;
  logic       drop;

  // A word is emitted when a pair completes or when flush closes out a lone half.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (bus.in_valid) begin
      if (pack_state == PACK_HALF) begin
        push      = 1'b1;
        push_word = make_word(bus.in_result, pend_result, LANES_PAIR, pend_flags | bus.in_fpcsr);
      end else if (flush) begin
        push      = 1'b1;
        push_word = make_word(16'h0000, bus.in_result, LANES_LONE, bus.in_fpcsr);
      end
    end else if (flush && pack_state == PACK_HALF) begin
      push      = 1'b1;
      push_word = make_word(16'h0000, pend_result, LANES_LONE, pend_flags);
    end
  end

  assign head_pop = bus.out_ready && !fifo_empty;
  assign drop     = push && fifo_full && !head_pop;

  bf16_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pack_word_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.out_ready),
    .wdata (push_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_word.data;
  assign bus.out_lanes = head_word.lanes;
  assign bus.out_flags = head_word.flags;

  // Clear is applied first so flags or a drop arriving in the same cycle survive it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_state   <= PACK_EMPTY;
      pend_result  <= '0;
      pend_flags   <= '0;
      sticky_flags <= '0;
      drop_err     <= 1'b0;
    end else begin
      sticky_flags <= (flags_clear ? '0 : sticky_flags) | (bus.in_valid ? bus.in_fpcsr : '0);
      drop_err     <= (flags_clear ? 1'b0 : drop_err) | drop;
      case (pack_state)
        PACK_EMPTY: begin
          if (bus.in_valid && !flush) begin
            pend_result <= bus.in_result;
            pend_flags  <= bus.in_fpcsr;
            pack_state  <= PACK_HALF;
          end
        end
        PACK_HALF: begin
          if (bus.in_valid || flush) pack_state <= PACK_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_pack_wb.sv
// Scoreboard bench for bf16_pack_wb: a queue-based reference model predicts every packed word
// and the status outputs; a negedge monitor pops the expected queue on each accepted word.
module tb_bf16_pack_wb;
  import bf16_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int W     = 38;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              flags_clear;
  fpcsr_t            sticky_flags;
  logic              drop_err;
  logic [LVL_W-1:0]  level;
  pack_state_t       pack_state;

  bf16_pack_wb_if bus();

  bf16_pack_wb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flush        (flush),
    .flags_clear  (flags_clear),
    .sticky_flags (sticky_flags),
    .drop_err     (drop_err),
    .level        (level),
    .pack_state   (pack_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [19:0]   half_q[$];
  int            m_level;
  fpcsr_t        m_sticky;
  logic          m_drop;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("level",      W'(level), W'(m_level));
    chk("in_ready",   W'(bus.in_ready), W'(m_level != DEPTH));
    chk("out_valid",  W'(bus.out_valid), W'(m_level != 0));
    chk("sticky",     W'(sticky_flags), W'(m_sticky));
    chk("drop_err",   W'(drop_err), W'(m_drop));
    chk("pack_state", W'(pack_state == PACK_HALF), W'(half_q.size() == 1));
  endtask

  // One clock of stimulus; the model predicts the state after the coming edge.
  task automatic cycle(input logic v, input logic [15:0] r, input logic [3:0] f,
                       input logic fl, input logic clr, input logic ordy);
    logic         pop;
    logic         push;
    logic         drp;
    logic [W-1:0] word;
    @(posedge clk);
    #1;
    check_state();
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_fpcsr  = f;
    flush         = fl;
    flags_clear   = clr;
    bus.out_ready = ordy;

    pop  = ordy && (m_level > 0);
    push = 1'b0;
    word = '0;
    if (v) half_q.push_back({f, r});
    if (half_q.size() == 2) begin
      word = {half_q[1][15:0], half_q[0][15:0], 2'b11, half_q[0][19:16] | half_q[1][19:16]};
      push = 1'b1;
      half_q.delete();
    end else if (fl && half_q.size() == 1) begin
      word = {16'h0000, half_q[0][15:0], 2'b01, half_q[0][19:16]};
      push = 1'b1;
      half_q.delete();
    end
    drp = push && (m_level == DEPTH) && !pop;
    if (push && !drp) exp_q.push_back(word);
    m_level  = m_level + ((push && !drp) ? 1 : 0) - (pop ? 1 : 0);
    m_sticky = (clr ? 4'h0 : m_sticky) | (v ? f : 4'h0);
    m_drop   = (clr ? 1'b0 : m_drop) | drp;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_level > 0 || exp_q.size() > 0); i++)
      cycle(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data",  W'(bus.out_data), W'(0));
    chk("rst_out_lanes", W'(bus.out_lanes), W'(0));
    chk("rst_out_flags", W'(bus.out_flags), W'(0));
    chk("rst_level",     W'(level), W'(0));
    chk("rst_sticky",    W'(sticky_flags), W'(0));
    chk("rst_drop_err",  W'(drop_err), W'(0));
    chk("rst_in_ready",  W'(bus.in_ready), W'(1));
  endtask

  task automatic clear_model();
    exp_q.delete();
    half_q.delete();
    m_level  = 0;
    m_sticky = '0;
    m_drop   = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    flags_clear   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every accepted head word must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_word actual=%0h required=none", {bus.out_data, bus.out_lanes, bus.out_flags});
        end else begin
          chk("out_word", {bus.out_data, bus.out_lanes, bus.out_flags}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_fpcsr  = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    flags_clear   = 1'b0;
    clear_model();
    #3;
    check_reset_outputs();
    #5;
    reset = 1'b0;

    // Pair pack, held then drained.
    cycle(1'b1, 16'h3F80, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hC000, 4'h1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();

    // Lone half closed by flush, then a same-cycle input+flush.
    cycle(1'b1, BF16_QNAN, 4'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 4'h2, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hAAAA, 4'h4, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    drain();

    // Overflow: five pairs into a four-deep FIFO with writeback stalled.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'(16'h1000 + i), 4'h0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    drain();
    idle(1, 1'b0);

    // Clear versus set in the same cycle.
    cycle(1'b1, 16'h4000, 4'h1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    drain();

    // Full FIFO with a pair completing on a popping cycle.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 16'(16'h2000 + i), 4'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2100, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2101, 4'h2, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    drain();

    // Reset with two words queued and a half pending.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 16'(16'h3000 + i), 4'h8, 1'b0, 1'b0, 1'b0);
    mid_reset();
    cycle(1'b1, 16'h3F00, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 99) < 70),
            16'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
            1'($urandom_range(0, 99) < 10),
            1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 99) < 55));
    end

    cycle(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    drain();
    idle(2, 1'b1);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
